// File: rtl/phi2_mon_pkg.sv
// Shared types and defaults for the phi2 clock monitor.
package phi2_mon_pkg;

    localparam int PERIOD_W           = 5;
    localparam int DEF_NOM_PERIOD     = 8;
    localparam int DEF_TOL            = 1;
    localparam int DEF_LOCK_COUNT     = 4;
    localparam int DEF_TIMEOUT        = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2,
        ST_LOST   = 2'd3
    } mon_state_e;

    function automatic logic period_in_tol(
        input logic [PERIOD_W-1:0] sample,
        input logic [PERIOD_W-1:0] lo,
        input logic [PERIOD_W-1:0] hi
    );
        return (sample >= lo) && (sample <= hi);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer plus history flop with registered rise/fall strobes.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d_in,
    output logic rise_stb,
    output logic fall_stb
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic hist_q,  hist_d;
    logic rise_q,  rise_d;
    logic fall_q,  fall_d;

    // next-state of synchronizer chain and edge strobes
    always_comb begin
        sync1_d = d_in;
        sync2_d = sync1_q;
        hist_d  = sync2_q;
        rise_d  = sync2_q & ~hist_q;
        fall_d  = ~sync2_q & hist_q;
    end

    // synchronizer, history and strobe registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            hist_q  <= hist_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign rise_stb = rise_q;
    assign fall_stb = fall_q;

endmodule

// File: rtl/phi2_monitor.sv
// phi2 period measurement and lock monitor.
// Optional PHI2_MON_STATS_EN adds an 8-bit saturating LOCKED->LOST counter.
module phi2_monitor
    import phi2_mon_pkg::*;
#(
    parameter int NOM_PERIOD = DEF_NOM_PERIOD,
    parameter int TOL        = DEF_TOL,
    parameter int LOCK_COUNT = DEF_LOCK_COUNT,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                phi2_in,
    output logic                rise_stb,
    output logic                fall_stb,
    output logic [PERIOD_W-1:0] period,
    output logic                locked,
    output logic                lost
`ifdef PHI2_MON_STATS_EN
    ,
    output logic [7:0]          lost_count
`endif
);

    localparam logic [PERIOD_W-1:0] GOOD_LO   = PERIOD_W'(NOM_PERIOD - TOL);
    localparam logic [PERIOD_W-1:0] GOOD_HI   = PERIOD_W'(NOM_PERIOD + TOL);
    localparam logic [PERIOD_W-1:0] TIMEOUT_C = PERIOD_W'(TIMEOUT);
    localparam logic [PERIOD_W-1:0] CNT_MAX   = {PERIOD_W{1'b1}};
    localparam logic [2:0]          LOCK_C    = 3'(LOCK_COUNT);

    mon_state_e          state_q, state_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [2:0]          good_q, good_d;
    logic                locked_q, locked_d;
    logic                lost_q, lost_d;
    logic                good_s;
    logic                timeout_s;

    sync_edge_det u_sync_edge_det (
        .clk      (clk),
        .rst      (rst),
        .d_in     (phi2_in),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
    );

    // interval counter, period capture and lock FSM next-state
    always_comb begin
        state_d   = state_q;
        good_d    = good_q;
        good_s    = period_in_tol(cnt_q, GOOD_LO, GOOD_HI);
        timeout_s = (cnt_q == TIMEOUT_C);

        if (rise_stb) begin
            cnt_d    = {{(PERIOD_W-1){1'b0}}, 1'b1};
            period_d = cnt_q;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d    = cnt_q + {{(PERIOD_W-1){1'b0}}, 1'b1};
            period_d = period_q;
        end else begin
            cnt_d    = cnt_q;
            period_d = period_q;
        end

        // a rise strobe always takes priority over a coincident timeout
        case (state_q)
            ST_IDLE: begin
                if (rise_stb) begin
                    state_d = ST_ACQ;
                    good_d  = 3'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACQ: begin
                if (rise_stb) begin
                    if (!good_s) begin
                        good_d = 3'd0;
                    end else if ((good_q + 3'd1) == LOCK_C) begin
                        state_d = ST_LOCKED;
                        good_d  = 3'd0;
                    end else begin
                        good_d = good_q + 3'd1;
                    end
                end else if (timeout_s) begin
                    state_d = ST_IDLE;
                    good_d  = 3'd0;
                end else begin
                    state_d = ST_ACQ;
                end
            end
            ST_LOCKED: begin
                if (rise_stb) begin
                    if (good_s) begin
                        state_d = ST_LOCKED;
                    end else begin
                        state_d = ST_LOST;
                    end
                end else if (timeout_s) begin
                    state_d = ST_LOST;
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            ST_LOST: begin
                if (rise_stb) begin
                    state_d = ST_ACQ;
                    good_d  = 3'd0;
                end else begin
                    state_d = ST_LOST;
                end
            end
            default: begin
                state_d = ST_IDLE;
                good_d  = 3'd0;
            end
        endcase

        locked_d = (state_d == ST_LOCKED);
        lost_d   = (state_d == ST_LOST);
    end

    // state, counter and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            good_q   <= 3'd0;
            locked_q <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            good_q   <= good_d;
            locked_q <= locked_d;
            lost_q   <= lost_d;
        end
    end

    assign period = period_q;
    assign locked = locked_q;
    assign lost   = lost_q;

`ifdef PHI2_MON_STATS_EN
    logic [7:0] lost_count_q, lost_count_d;

    // count LOCKED->LOST transitions, saturating
    always_comb begin
        if ((state_q == ST_LOCKED) && (state_d == ST_LOST) && (lost_count_q != 8'hFF)) begin
            lost_count_d = lost_count_q + 8'd1;
        end else begin
            lost_count_d = lost_count_q;
        end
    end

    // loss statistics register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lost_count_q <= 8'd0;
        end else begin
            lost_count_q <= lost_count_d;
        end
    end

    assign lost_count = lost_count_q;
`endif

endmodule

// File: tb/tb_phi2_monitor.sv
// Directed self-checking bench for phi2_monitor (default parameters).
module tb_phi2_monitor;

    logic       clk;
    logic       rst;
    logic       phi2_in;
    logic       rise_stb;
    logic       fall_stb;
    logic [4:0] period;
    logic       locked;
    logic       lost;
`ifdef PHI2_MON_STATS_EN
    logic [7:0] lost_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    int cyc           = 0;
    int rise_cnt      = 0;
    int last_rise_cyc = 0;
    int lock_cyc      = 0;
    logic locked_prev = 1'b0;
    int r0;

    phi2_monitor dut (
        .clk      (clk),
        .rst      (rst),
        .phi2_in  (phi2_in),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb),
        .period   (period),
        .locked   (locked),
        .lost     (lost)
`ifdef PHI2_MON_STATS_EN
        ,
        .lost_count (lost_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // observe strobes and lock onset on the falling edge
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rise_stb === 1'b1) begin
            rise_cnt      <= rise_cnt + 1;
            last_rise_cyc <= cyc;
        end
        if ((locked === 1'b1) && (locked_prev === 1'b0)) begin
            lock_cyc <= cyc;
        end
        locked_prev <= locked;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v);
        @(posedge clk);
        #1 phi2_in = v;
    endtask

    task automatic step_n(input logic v, input int n);
        for (int i = 0; i < n; i++) step(v);
    endtask

    task automatic drive_period(input int len, input int hi);
        for (int i = 0; i < len; i++) step(i < hi);
    endtask

    initial begin
        rst     = 1'b1;
        phi2_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_rise",   32'(rise_stb), 32'd0);
        check_val("rst_fall",   32'(fall_stb), 32'd0);
        check_val("rst_period", 32'(period),   32'd0);
        check_val("rst_locked", 32'(locked),   32'd0);
        check_val("rst_lost",   32'(lost),     32'd0);
`ifdef PHI2_MON_STATS_EN
        check_val("rst_lost_count", 32'(lost_count), 32'd0);
`endif
        @(posedge clk);
        #1 rst = 1'b0;

        // steady 8-cycle phi2: lock on the cycle after the 5th rise
        drive_period(8, 4);
        drive_period(8, 4);
        check_val("acq_period2", 32'(period), 32'd8);
        drive_period(8, 4);
        drive_period(8, 4);
        check_val("acq_not_locked4", 32'(locked), 32'd0);
        step_n(1'b1, 3);
        check_val("rise_latency", 32'(rise_stb), 32'd0);
        step(1'b1);
        check_val("rise5_stb", 32'(rise_stb), 32'd1);
        check_val("rise5_unlocked", 32'(locked), 32'd0);
        step(1'b0);
        check_val("rise_one_wide", 32'(rise_stb), 32'd0);
        check_val("lock_after_5", 32'(locked), 32'd1);
        step_n(1'b0, 2);
        step(1'b0);
        check_val("fall_stb", 32'(fall_stb), 32'd1);
        check_val("lock_delay", 32'(lock_cyc - last_rise_cyc), 32'd1);
        check_val("rise_count5", 32'(rise_cnt), 32'd5);

        // one 10-cycle period while locked
        drive_period(10, 4);
        step_n(1'b1, 4);
        check_val("bad_still_locked", 32'(locked), 32'd1);
        step(1'b0);
        check_val("bad_period", 32'(period), 32'd10);
        check_val("bad_lost",   32'(lost),   32'd1);
        check_val("bad_unlock", 32'(locked), 32'd0);
        step_n(1'b0, 3);
        drive_period(8, 4);
        check_val("relost_acq_lost",   32'(lost),   32'd0);
        check_val("relost_acq_locked", 32'(locked), 32'd0);
        drive_period(8, 4);
        drive_period(8, 4);
        drive_period(8, 4);
        check_val("relock_not_yet", 32'(locked), 32'd0);
        drive_period(8, 4);
        check_val("relock", 32'(locked), 32'd1);

        // phi2 stuck low: loss when the counter reaches 16
        step_n(1'b0, 12);
        check_val("tmo_before_lost",   32'(lost),   32'd0);
        check_val("tmo_before_locked", 32'(locked), 32'd1);
        step(1'b0);
        check_val("tmo_lost",   32'(lost),   32'd1);
        check_val("tmo_locked", 32'(locked), 32'd0);
        check_val("tmo_period", 32'(period), 32'd8);
        step_n(1'b0, 30);
        check_val("lost_no_timeout_exit", 32'(lost), 32'd1);
`ifdef PHI2_MON_STATS_EN
        check_val("lost_count2", 32'(lost_count), 32'd2);
`endif

        // 7/9 alternating periods lock; first interval saturated at 31
        drive_period(7, 3);
        check_val("sat_period", 32'(period), 32'd31);
        check_val("lost_to_acq", 32'(lost), 32'd0);
        drive_period(9, 4);
        drive_period(7, 3);
        drive_period(9, 4);
        check_val("alt_not_yet", 32'(locked), 32'd0);
        drive_period(7, 3);
        check_val("alt_locked", 32'(locked), 32'd1);
        check_val("alt_period", 32'(period), 32'd9);

        // 6-cycle periods: out of tolerance, never lock
        drive_period(6, 3);
        drive_period(6, 3);
        check_val("p6_lost", 32'(lost), 32'd1);
        for (int i = 0; i < 4; i++) drive_period(6, 3);
        check_val("p6_locked", 32'(locked), 32'd0);
        check_val("p6_lost_end", 32'(lost), 32'd0);
        check_val("p6_period", 32'(period), 32'd6);

        // a bad period after 3 good ones clears the good count
        drive_period(8, 4);
        drive_period(8, 4);
        drive_period(8, 4);
        drive_period(6, 3);
        drive_period(8, 4);
        drive_period(8, 4);
        drive_period(8, 4);
        check_val("clear_no_lock", 32'(locked), 32'd0);
        drive_period(8, 4);
        drive_period(8, 4);
        check_val("clear_relock", 32'(locked), 32'd1);

        // rise coinciding with counter == TIMEOUT in ACQ
        step_n(1'b0, 20);
        check_val("coin_lost", 32'(lost), 32'd1);
        drive_period(16, 4);
        drive_period(8, 4);
        check_val("coin_period", 32'(period), 32'd16);
        check_val("coin_locked", 32'(locked), 32'd0);
        check_val("coin_lost2",  32'(lost),   32'd0);
        drive_period(8, 4);
        drive_period(8, 4);
        drive_period(8, 4);
        check_val("coin_goodcnt0", 32'(locked), 32'd0);
        drive_period(8, 4);
        check_val("coin_stays_acq", 32'(locked), 32'd1);

        // async reset pulse while locked with phi2 high
        step(1'b1);
        r0 = rise_cnt;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_val("arst_rise",   32'(rise_stb), 32'd0);
        check_val("arst_period", 32'(period),   32'd0);
        check_val("arst_locked", 32'(locked),   32'd0);
        check_val("arst_lost",   32'(lost),     32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        step_n(1'b1, 3);
        check_val("arst_rise_after", 32'(rise_stb), 32'd1);
        step_n(1'b0, 4);
        check_val("arst_one_rise", 32'(rise_cnt - r0), 32'd1);
        check_val("arst_acq_locked", 32'(locked), 32'd0);
        drive_period(8, 4);
        drive_period(8, 4);
        drive_period(8, 4);
        check_val("arst_not_yet", 32'(locked), 32'd0);
        drive_period(8, 4);
        check_val("arst_relock", 32'(locked), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
